uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver with configurable frame format and an output FIFO. Recovers framed serial data from an asynchronous line using an OVERSAMPLE-times baud tick, majority-vote mid-bit sampling and false-start rejection. Delivers received words with per-word parity and framing flags over a valid/ready interface. Sits on the receive side of the UART, alongside the transmitter, and replaces the single-register, bit-clocked receiver.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 24 ++
 rtl/uart_rx_os.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_os.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART: receiver FSM states, parity
// encoding and the baud-tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Clamped to 1 so a too-fast baud setting still yields a tick every cycle.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a 1-cycle tick every DIV clk2 cycles.
// DIV=1 degenerates to a constant tick.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk2,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchroniser, majority-vote bit recovery with
// false-start rejection, and a first-word-fall-through output FIFO.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk2,
    input  logic                          rst,
    input  logic                          serialdata_in,
    input  logic                          parity_type,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [SCW-1:0] SC_PRE  = SCW'(M - 1);
    localparam logic [SCW-1:0] SC_MID  = SCW'(M);
    localparam logic [SCW-1:0] SC_POST = SCW'(M + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     BC_LAST = 4'(DATA_BITS - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    typedef struct packed {
        logic                 ferr;
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } rx_word_t;

    logic                 sync1, sync2, rx_s;
    logic                 tick;
    rx_state_e            state;
    logic [SCW-1:0]       sc;
    logic [1:0]           smp;
    logic                 maj;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_lat;
    logic                 perr, ferr;
    logic                 sample_pt, last_stop, push;
    rx_word_t             push_word;

    // Both flops idle high so reset never looks like a start edge.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= serialdata_in;
            sync2 <= sync1;
        end
    end
    assign rx_s = sync2;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk2 (clk2),
        .rst  (rst),
        .tick (tick)
    );

    assign maj       = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign sample_pt = tick && (sc == SC_POST) &&
                       (state != ST_IDLE) && (state != ST_WAIT_HIGH);
    assign last_stop = (stop_cnt == STOP_LAST);
    // Push at the vote of the last stop bit, leaving half a bit to re-arm.
    assign push      = sample_pt && (state == ST_STOP) && last_stop;
    assign push_word = '{ferr: ferr | ~maj, perr: perr, data: shreg};
    assign rx_busy   = (state != ST_IDLE);

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sc       <= '0;
            smp      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_lat  <= PAR_EVEN;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && !rx_s) begin
                        sc       <= '0;
                        par_lat  <= parity_type;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: begin
                    if (tick) begin
                        sc <= (sc == SC_LAST) ? '0 : sc + SCW'(1);
                        if (sc == SC_PRE) smp[0] <= rx_s;
                        if (sc == SC_MID) smp[1] <= rx_s;
                        if (sc == SC_POST) begin
                            case (state)
                                ST_START:  if (maj) state <= ST_IDLE;
                                ST_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
                                ST_PARITY: perr <= maj ^ (^shreg) ^ (par_lat == PAR_ODD);
                                ST_STOP: begin
                                    if (!maj) ferr <= 1'b1;
                                    // A low last stop is a break: hold off until the line recovers.
                                    if (last_stop) state <= maj ? ST_IDLE : ST_WAIT_HIGH;
                                end
                                default: ;
                            endcase
                        end
                        if (sc == SC_LAST) begin
                            case (state)
                                ST_START: state <= ST_DATA;
                                ST_DATA: begin
                                    if (bit_cnt == BC_LAST)
                                        state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                                    else
                                        bit_cnt <= bit_cnt + 4'd1;
                                end
                                ST_PARITY: state <= ST_STOP;
                                ST_STOP:   stop_cnt <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    rx_word_t      mem [FIFO_DEPTH];
    rx_word_t      head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, accept;

    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    assign pop    = rx_valid && rx_ready;
    // A pop on the same edge frees the slot the push needs.
    assign accept = push && (!full || pop);

    always_ff @(posedge clk2) begin
        if (accept) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            if (push && !accept) overrun <= 1'b1;
            else if (pop)        overrun <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? head.data : '0;
    assign parity_err = rx_valid & head.perr;
    assign frame_err  = rx_valid & head.ferr;
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 16 clk2 cycles per bit (DIV=1, 8-bit data,
// parity enabled, one stop bit, 4-deep FIFO).
module tb_uart_rx_os;

    logic       clk2 = 1'b0;
    logic       rst = 1'b1;
    logic       serialdata_in = 1'b1;
    logic       parity_type = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       parity_err, frame_err, rx_valid, overrun, rx_busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;

    always #5 clk2 = ~clk2;

    uart_rx_os #(
        .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1), .OVERSAMPLE(16),
        .CLK_FREQ(16000000), .BAUD(1000000), .FIFO_DEPTH(4)
    ) dut (
        .clk2(clk2), .rst(rst), .serialdata_in(serialdata_in), .parity_type(parity_type),
        .rx_data(rx_data), .parity_err(parity_err), .frame_err(frame_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
        .rx_busy(rx_busy), .fifo_count(fifo_count)
    );

    task automatic send_bit(input logic b);
        serialdata_in = b;
        repeat (16) @(posedge clk2);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(posedge clk2); #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        total++; if ({rx_data, parity_err, frame_err} !== 10'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {rx_data, parity_err, frame_err}); end
        total++; if ({rx_valid, overrun, rx_busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {rx_valid, overrun, rx_busy}); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        @(posedge clk2); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk2); #1;
    endtask

    task automatic test_even_parity();
        logic [7:0] d = 8'hA5;
        parity_type = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        serialdata_in = 1'b1;
        repeat (12) @(posedge clk2); #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL even_early_valid got=%b want=0", rx_valid); end
        @(posedge clk2); #1;
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL even_push_valid got=%b want=1", rx_valid); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL even_data got=%h want=a5", rx_data); end
        total++; if ({parity_err, frame_err} !== 2'b00) begin bad++; $display("FAIL even_flags got=%b want=00", {parity_err, frame_err}); end
        repeat (3) @(posedge clk2); #1;
        pop_one();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL even_pop_empty got=%b want=0", rx_valid); end
    endtask

    task automatic test_odd_parity();
        parity_type = 1'b1;
        send_frame(8'h3C, 1'b0);
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL odd_bad_data got=%h want=3c", rx_data); end
        total++; if ({parity_err, frame_err} !== 2'b10) begin bad++; $display("FAIL odd_bad_flags got=%b want=10", {parity_err, frame_err}); end
        pop_one();
        send_frame(8'h3C, 1'b1);
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL odd_good_data got=%h want=3c", rx_data); end
        total++; if ({parity_err, frame_err} !== 2'b00) begin bad++; $display("FAIL odd_good_flags got=%b want=00", {parity_err, frame_err}); end
        pop_one();
        parity_type = 1'b0;
    endtask

    task automatic test_false_start();
        serialdata_in = 1'b0;
        repeat (6) @(posedge clk2); #1;
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b want=1", rx_busy); end
        serialdata_in = 1'b1;
        repeat (10) @(posedge clk2); #1;
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", rx_busy); end
        repeat (200) @(posedge clk2); #1;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_no_push got=%0d want=0", fifo_count); end
    endtask

    task automatic test_break();
        serialdata_in = 1'b0;
        repeat (20 * 16) @(posedge clk2); #1;
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL break_count got=%0d want=1", fifo_count); end
        total++; if ({rx_data, parity_err, frame_err} !== {8'h00, 2'b01}) begin bad++; $display("FAIL break_word got=%h want=001", {rx_data, parity_err, frame_err}); end
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL break_wait_busy got=%b want=1", rx_busy); end
        serialdata_in = 1'b1;
        repeat (16) @(posedge clk2); #1;
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL break_recover got=%b want=0", rx_busy); end
        send_frame(8'h81, 1'b0);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL break_next_count got=%0d want=2", fifo_count); end
        pop_one();
        total++; if ({rx_data, parity_err, frame_err} !== {8'h81, 2'b00}) begin bad++; $display("FAIL break_next_word got=%h want=204", {rx_data, parity_err, frame_err}); end
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_frame(d, ^d);
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d want=4", fifo_count); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            total++; if (rx_data !== 8'(i)) begin bad++; $display("FAIL ovr_head%0d got=%h want=%h", i, rx_data, 8'(i)); end
            pop_one();
            if (i == 1) begin
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
            end
        end
        total++; if ({rx_valid, fifo_count} !== 4'b0000) begin bad++; $display("FAIL ovr_drained got=%b want=0000", {rx_valid, fifo_count}); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'h5A;
        send_frame(8'h11, 1'b0);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL rstmf_pre got=%0d want=1", fifo_count); end
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        serialdata_in = d[3];
        repeat (5) @(posedge clk2); #1;
        rst = 1'b1;
        #1;
        total++; if ({rx_data, parity_err, frame_err} !== 10'h0) begin bad++; $display("FAIL rstmf_data got=%h want=0", {rx_data, parity_err, frame_err}); end
        total++; if ({rx_valid, overrun, rx_busy, fifo_count} !== 6'h0) begin bad++; $display("FAIL rstmf_flags got=%b want=000000", {rx_valid, overrun, rx_busy, fifo_count}); end
        serialdata_in = 1'b1;
        repeat (3) @(posedge clk2); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk2); #1;
        send_frame(8'h5A, 1'b0);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL rstmf_count got=%0d want=1", fifo_count); end
        total++; if ({rx_data, parity_err, frame_err} !== {8'h5A, 2'b00}) begin bad++; $display("FAIL rstmf_word got=%h want=168", {rx_data, parity_err, frame_err}); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_false_start();
        test_break();
        test_overrun();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
